// File: rtl/fu_mul_pkg.sv
// Shared definitions for the pipelined multiply functional unit.
//   op_t          2-bit operation select
//   MUL..MULHU    operation encodings
//   stage_ctl_t   control record {valid, op} for a pipeline stage. The tag width is fixed per
//                 instance, so the tag travels next to this record rather than inside it.
//   a_is_signed / b_is_signed  operand extension rules per operation
package fu_mul_pkg;

  typedef logic [1:0] op_t;

  localparam op_t MUL    = 2'b00;  // low word of the product
  localparam op_t MULH   = 2'b01;  // high word, signed x signed
  localparam op_t MULHSU = 2'b10;  // high word, signed rs1 x unsigned rs2
  localparam op_t MULHU  = 2'b11;  // high word, unsigned x unsigned

  typedef struct packed {
    logic valid;
    op_t  op;
  } stage_ctl_t;

  // rs1 is sign-extended for MULH and MULHSU.
  function automatic logic a_is_signed(op_t op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  // rs2 is sign-extended only for MULH.
  function automatic logic b_is_signed(op_t op);
    return op == MULH;
  endfunction

endpackage

// File: rtl/fu_mul_stage_reg.sv
// One pipeline stage register of the multiply unit.
// Ports:
//   clk_i    clock
//   clr_i    synchronous clear of the valid bit only (reset or flush)
//   en_i     stage load enable (pipeline advance)
//   valid_i  incoming valid bit
//   data_i   incoming payload (DataW bits)
//   valid_o  registered valid bit
//   data_o   registered payload; meaningless while valid_o is low
module fu_mul_stage_reg #(
  parameter int unsigned DataW = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [DataW-1:0] data_i,
  output logic             valid_o,
  output logic [DataW-1:0] data_o
);

  logic             valid_q;
  logic [DataW-1:0] data_q;

  // Clear has priority over a load so reset and flush always win.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid_q <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
    end
  end

  // Payload has no reset: consumers only look at it behind the valid bit.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fu_mul_pipe.sv
// Pipelined integer multiply functional unit with tag, back-pressure and flush.
// Accepts one op per cycle, keeps up to LATENCY ops in flight, and preserves order.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset, kills every op in flight
//   flush      synchronous kill of every op in flight; blocks acceptance this cycle
//   in_valid   op presented on op/A/B/tag_in
//   in_ready   unit can accept this cycle
//   op         00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   A, B       operands (rs1, rs2)
//   tag_in     tag of the incoming op
//   out_valid  res/tag_out hold a completed op
//   out_ready  consumer takes the result this cycle
//   res        selected product word, 0 when out_valid is low
//   tag_out    tag of the completed op, 0 when out_valid is low
//   busy       any stage holds a valid op
module fu_mul_pipe
  import fu_mul_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 7,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  localparam int unsigned ExtW  = WIDTH + 1;
  localparam int unsigned ProdW = 2 * WIDTH + 2;
  // Stage 1 payload: {op, tag, a_ext, b_ext}
  localparam int unsigned S1W   = 2 + TAG_W + 2 * ExtW;
  // Stage 2..LATENCY payload: {op, tag, product}
  localparam int unsigned SnW   = 2 + TAG_W + ProdW;

  if ((LATENCY < 2) || (LATENCY > 16)) begin : g_latency_check
    $fatal(1, "fu_mul_pipe: LATENCY must lie in 2..16");
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic advance;
  logic accept;
  logic clr;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance & ~flush & ~rst;
  assign accept   = in_valid & in_ready;
  assign clr      = rst | flush;

  logic [LATENCY:1] valid_q;

  assign busy = |valid_q;

  // ---------------------------------------------------------------------------
  // Stage 1: operand extension
  // ---------------------------------------------------------------------------
  logic [ExtW-1:0] a_ext;
  logic [ExtW-1:0] b_ext;

  assign a_ext = {a_is_signed(op) & A[WIDTH-1], A};
  assign b_ext = {b_is_signed(op) & B[WIDTH-1], B};

  logic [S1W-1:0] s1_data;

  fu_mul_stage_reg #(
    .DataW (S1W)
  ) u_stage1 (
    .clk_i   (clk),
    .clr_i   (clr),
    .en_i    (advance),
    .valid_i (accept),
    .data_i  ({op, tag_in, a_ext, b_ext}),
    .valid_o (valid_q[1]),
    .data_o  (s1_data)
  );

  op_t              s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic [ExtW-1:0]  s1_a;
  logic [ExtW-1:0]  s1_b;

  assign s1_op  = s1_data[S1W-1 -: 2];
  assign s1_tag = s1_data[2*ExtW +: TAG_W];
  assign s1_a   = s1_data[ExtW +: ExtW];
  assign s1_b   = s1_data[0 +: ExtW];

  // ---------------------------------------------------------------------------
  // Stage 2: full signed product of the extended operands. Extending both to the
  // product width first makes the multiply exact for every operand combination.
  // ---------------------------------------------------------------------------
  logic signed [ProdW-1:0] prod;

  assign prod = signed'({{(ProdW - ExtW){s1_a[ExtW-1]}}, s1_a}) *
                signed'({{(ProdW - ExtW){s1_b[ExtW-1]}}, s1_b});

  // ---------------------------------------------------------------------------
  // Stages 2..LATENCY: product register followed by pure delay
  // ---------------------------------------------------------------------------
  logic [SnW-1:0] sn_data [2:LATENCY];

  for (genvar k = 2; k <= LATENCY; k++) begin : g_stage
    logic [SnW-1:0] stage_in;

    if (k == 2) begin : g_mul
      assign stage_in = {s1_op, s1_tag, prod};
    end else begin : g_delay
      assign stage_in = sn_data[k-1];
    end

    fu_mul_stage_reg #(
      .DataW (SnW)
    ) u_stage (
      .clk_i   (clk),
      .clr_i   (clr),
      .en_i    (advance),
      .valid_i (valid_q[k-1]),
      .data_i  (stage_in),
      .valid_o (valid_q[k]),
      .data_o  (sn_data[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Output select and masking
  // ---------------------------------------------------------------------------
  stage_ctl_t       out_ctl;
  logic [TAG_W-1:0] last_tag;
  logic [ProdW-1:0] last_prod;

  assign out_ctl.valid = valid_q[LATENCY];
  assign out_ctl.op    = sn_data[LATENCY][SnW-1 -: 2];
  assign last_tag      = sn_data[LATENCY][ProdW +: TAG_W];
  assign last_prod     = sn_data[LATENCY][ProdW-1:0];

  assign out_valid = out_ctl.valid;

  always_comb begin
    res     = '0;
    tag_out = '0;
    if (out_ctl.valid) begin
      tag_out = last_tag;
      if (out_ctl.op == MUL) begin
        res = last_prod[WIDTH-1:0];
      end else begin
        res = last_prod[2*WIDTH-1:WIDTH];
      end
    end
  end

  // The two guard bits above the 2*WIDTH product only keep the extended multiply exact.
  logic unused_prod_hi;
  assign unused_prod_hi = ^last_prod[ProdW-1:2*WIDTH];

endmodule
